// File: rtl/wfm_capture_pack_if.sv
// Packed PicoRV32 memory bus as seen by one peripheral on the shared bus.
// fwd = {wdata[31:0], wstrb[3:0], valid, addr[31:0]}; ret = {ready, rdata[31:0]}.
interface wfm_capture_pack_if;
  logic [68:0] mem_packed_fwd;
  logic [32:0] mem_packed_ret;

  modport master (output mem_packed_fwd, input  mem_packed_ret);
  modport slave  (input  mem_packed_fwd, output mem_packed_ret);
endinterface

// File: rtl/wfm_capture_pack.sv
// Two-channel ADC burst capture into a dual-clock RAM, read back over the
// packed CPU bus. Arm/done handshakes cross domains as toggles.
module wfm_capture_pack #(
  parameter logic [7:0] BASE_ADDR  = 8'h03,
  parameter logic [7:0] BASE2_ADDR = 8'h00,
  parameter int         N_CH       = 2,
  parameter int         AW         = 8
) (
  input  logic                 mem_clk,
  input  logic                 reset,
  input  logic                 dsp_clk,
  input  logic [16*N_CH-1:0]   adc_out_data,
  wfm_capture_pack_if.slave    bus
);

  localparam int DW     = 16 * N_CH;
  localparam int CH_LOG = (N_CH == 2) ? 1 : 0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} cap_state_t;

  logic [DW-1:0] r_mem [2**AW];

  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic          w_valid;
  logic          w_sel;
  logic          w_same;
  logic          w_new;
  logic          w_arm;
  logic          w_done_evt;
  logic [8:0]    w_word;
  logic [8:0]    w_samp_full;
  logic [AW-1:0] w_sample;
  logic          w_ch;
  logic [4:0]    w_off;
  logic [DW-1:0] w_rd_word;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_acked;
  logic [31:0]   r_last_addr;
  logic [3:0]    r_last_wstrb;
  logic          r_busy;
  logic          r_done;
  logic          r_req_tgl;
  logic          r_done_s1;
  logic          r_done_s2;
  logic          r_done_last;

  logic          r_dsp_rst_s1;
  logic          r_dsp_rst_s2;
  logic          r_req_s1;
  logic          r_req_s2;
  logic          r_req_last;
  cap_state_t    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_done_tgl;
  logic          w_start;
  logic          w_we;

  assign {w_wdata, w_wstrb, w_valid, w_addr} = bus.mem_packed_fwd;
  assign bus.mem_packed_ret = {r_ready, r_rdata};

  assign w_sel  = w_valid && (w_addr[31:24] == BASE_ADDR) && (w_addr[23:16] == BASE2_ADDR);
  // A held request with unchanged address/strobe is the same transaction: ack it only once.
  assign w_same = r_acked && (w_addr == r_last_addr) && (w_wstrb == r_last_wstrb);
  assign w_new  = w_sel && !w_same;

  assign w_word      = w_addr[10:2];
  assign w_samp_full = w_word >> CH_LOG;
  assign w_sample    = w_samp_full[AW-1:0];
  assign w_ch        = (N_CH == 2) ? w_word[0] : 1'b0;
  assign w_off       = {w_ch, 4'b0000};
  assign w_rd_word   = r_mem[w_sample];

  assign w_arm      = w_new && (|w_wstrb) && w_addr[11] && (w_word == 9'd0) && w_wdata[0] && !r_busy;
  assign w_done_evt = (r_done_s2 ^ r_done_last) && r_busy;

  assign w_unused = &{1'b0, w_addr[15:12], w_addr[1:0], w_wdata[31:1]};

  // Read data mux: buffer sample, status word, or zero.
  always_comb begin
    w_rd_val = 32'h0000_0000;
    if (!w_addr[11]) begin
      w_rd_val = {16'h0000, w_rd_word[w_off +: 16]};
    end else if (w_word == 9'd0) begin
      w_rd_val = {30'h0000_0000, r_done, r_busy};
    end else begin
      w_rd_val = 32'h0000_0000;
    end
  end

  // Bus response, arm/busy/done control and done-toggle synchronizer.
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      r_ready      <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_acked      <= 1'b0;
      r_last_addr  <= 32'h0000_0000;
      r_last_wstrb <= 4'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_req_tgl    <= 1'b0;
      r_done_s1    <= 1'b0;
      r_done_s2    <= 1'b0;
      r_done_last  <= 1'b0;
    end else begin
      r_done_s1   <= r_done_tgl;
      r_done_s2   <= r_done_s1;
      r_done_last <= r_done_s2;
      if (w_new) begin
        r_ready      <= 1'b1;
        r_rdata      <= w_rd_val;
        r_acked      <= 1'b1;
        r_last_addr  <= w_addr;
        r_last_wstrb <= w_wstrb;
      end else begin
        r_ready <= 1'b0;
        r_rdata <= 32'h0000_0000;
        r_acked <= r_acked && w_sel;
      end
      // Arm is only accepted while idle, so it can never coincide with a done event.
      if (w_arm) begin
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_req_tgl <= ~r_req_tgl;
      end else if (w_done_evt) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_busy <= r_busy;
        r_done <= r_done;
      end
    end
  end

  // Bring the bus-side reset into the sample clock domain.
  always_ff @(posedge dsp_clk) begin
    r_dsp_rst_s1 <= reset;
    r_dsp_rst_s2 <= r_dsp_rst_s1;
  end

  // The first sample is written on the edge that detects the arm toggle.
  assign w_start = (r_state == ST_IDLE) && (r_req_s2 ^ r_req_last);
  assign w_we    = r_dsp_rst_s2 && (w_start || (r_state == ST_RUN));

  // Capture FSM with arm-toggle synchronizer and done toggle.
  always_ff @(posedge dsp_clk) begin
    if (!r_dsp_rst_s2) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req_s1   <= 1'b0;
      r_req_s2   <= 1'b0;
      r_req_last <= 1'b0;
      r_done_tgl <= 1'b0;
    end else begin
      r_req_s1   <= r_req_tgl;
      r_req_s2   <= r_req_s1;
      r_req_last <= r_req_s2;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_cnt   <= {{(AW-1){1'b0}}, 1'b1};
          end else begin
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (r_cnt == {AW{1'b1}}) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_done_tgl <= ~r_done_tgl;
          end else begin
            r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Capture RAM write port.
  always_ff @(posedge dsp_clk) begin
    if (w_we) begin
      r_mem[r_cnt] <= adc_out_data;
    end
  end

endmodule

// File: tb/tb_wfm_capture_pack.sv
// Directed bench for wfm_capture_pack: bus handshake, status, capture contents,
// double arm and reset abort.
module tb_wfm_capture_pack;

  logic        mem_clk = 1'b0;
  logic        dsp_clk = 1'b0;
  logic        reset   = 1'b0;
  logic [31:0] adc_out_data = 32'hdeadbeaf;

  int n_tests = 0;
  int n_fail  = 0;

  wfm_capture_pack_if bus ();

  wfm_capture_pack dut (
    .mem_clk      (mem_clk),
    .reset        (reset),
    .dsp_clk      (dsp_clk),
    .adc_out_data (adc_out_data),
    .bus          (bus)
  );

  initial forever #5 mem_clk = ~mem_clk;
  initial forever #7 dsp_clk = ~dsp_clk;

  initial forever begin
    @(negedge dsp_clk);
    adc_out_data = (adc_out_data == 32'hdeadbeaf) ? 32'h21524150 : 32'hdeadbeaf;
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        exp_got;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  localparam logic [31:0] STAT = 32'h0300_0800;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic got, output logic [31:0] rd, output int lat,
                      output logic reack, output logic leak);
    got = 1'b0; rd = 32'h0; lat = 0; reack = 1'b0; leak = 1'b0;
    @(posedge mem_clk); #1;
    bus.mem_packed_fwd = {d, s, 1'b1, a};
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge mem_clk);
      if (bus.mem_packed_ret[32]) begin
        got = 1'b1;
        rd  = bus.mem_packed_ret[31:0];
      end else begin
        lat++;
        if (bus.mem_packed_ret[31:0] != 32'h0) leak = 1'b1;
      end
    end
    if (got) begin
      @(negedge mem_clk);
      reack = bus.mem_packed_ret[32];
    end
    @(posedge mem_clk); #1;
    bus.mem_packed_fwd = 69'h0;
  endtask

  task automatic rd_status(output logic [31:0] st);
    logic g, ra, lk; int lt;
    xfer(STAT, 4'h0, 32'h0, g, st, lt, ra, lk);
    if (!g) st = 32'hffff_ffff;
  endtask

  task automatic arm();
    logic g, ra, lk; int lt; logic [31:0] r;
    xfer(STAT, 4'hf, 32'h1, g, r, lt, ra, lk);
    chk("arm_ack", {31'h0, g}, 32'h1);
  endtask

  task automatic wait_done(output logic ok, output int bad);
    logic [31:0] st;
    ok = 1'b0; bad = 0;
    for (int k = 0; k < 1500 && !ok; k++) begin
      rd_status(st);
      if (st == 32'h2) ok = 1'b1;
      else if (st != 32'h1) bad++;
    end
  endtask

  // Reads buffer words 0..nwords-1; sample j alternates between the two ADC patterns.
  task automatic check_buffer(input int nwords);
    logic g0, g1, ra0, ra1, lk0, lk1, phase;
    logic [31:0] lo, hi;
    logic [15:0] exp_lo, exp_hi;
    int l0, l1, dead_cnt;
    dead_cnt = 0; phase = 1'b0;
    for (int j = 0; j < nwords / 2; j++) begin
      xfer(32'h0300_0000 | (32'(2 * j) << 2), 4'h0, 32'h0, g0, lo, l0, ra0, lk0);
      xfer(32'h0300_0000 | (32'(2 * j + 1) << 2), 4'h0, 32'h0, g1, hi, l1, ra1, lk1);
      if (j == 0) phase = (lo[15:0] == 16'h4150);
      exp_lo = (phase ^ j[0]) ? 16'h4150 : 16'hbeaf;
      exp_hi = (phase ^ j[0]) ? 16'h2152 : 16'hdead;
      chk("buf_hs", {26'h0, g0, g1, ra0, ra1, l0 == 1, l1 == 1}, {26'h0, 6'b110011});
      chk("buf_even", lo, {16'h0, exp_lo});
      chk("buf_odd", hi, {16'h0, exp_hi});
      if (hi == 32'h0000_dead) dead_cnt++;
    end
    chk("dead_seen", {31'h0, dead_cnt > 0}, 32'h1);
  endtask

  initial begin
    logic g, ra, lk, ok;
    logic [31:0] r, st;
    int lt, bad;

    bus.mem_packed_fwd = 69'h0;

    vecs[0]  = '{32'h0300_0800, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[1]  = '{32'h0300_0804, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[2]  = '{32'h0300_0814, 4'hf, 32'h1,         1'b1, 1'b1, 32'h0};
    vecs[3]  = '{32'h0300_0800, 4'h1, 32'h2,         1'b1, 1'b1, 32'h0};
    vecs[4]  = '{32'h0300_0800, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[5]  = '{32'h0200_0800, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[6]  = '{32'h0301_0800, 4'hf, 32'h1,         1'b0, 1'b0, 32'h0};
    vecs[7]  = '{32'h0300_0000, 4'hf, 32'h1,         1'b1, 1'b0, 32'h0};
    vecs[8]  = '{32'h0300_0800, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[9]  = '{32'h8300_0000, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[10] = '{32'h0310_0000, 4'hf, 32'hffff_ffff, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{32'h0300_0800, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0};

    // Reset window with a status access in it.
    xfer(STAT, 4'h0, 32'h0, g, r, lt, ra, lk);
    chk("rst_no_ready", {31'h0, g}, 32'h0);
    chk("rst_no_rdata", {31'h0, lk}, 32'h0);
    chk("rst_ret_zero", {31'h0, |bus.mem_packed_ret}, 32'h0);
    @(posedge mem_clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge mem_clk);

    foreach (vecs[i]) begin
      xfer(vecs[i].addr, vecs[i].strb, vecs[i].wdata, g, r, lt, ra, lk);
      chk($sformatf("vec%0d_ready", i), {31'h0, g}, {31'h0, vecs[i].exp_got});
      if (vecs[i].exp_got) begin
        chk($sformatf("vec%0d_lat", i), 32'(lt), 32'd1);
        chk($sformatf("vec%0d_reack", i), {31'h0, ra}, 32'h0);
        if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      end else begin
        chk($sformatf("vec%0d_rdata0", i), {31'h0, lk}, 32'h0);
      end
    end

    // Double arm: one capture, busy held until done.
    arm();
    arm();
    rd_status(st);
    chk("busy_after_arm", st, 32'h1);
    wait_done(ok, bad);
    chk("capture_done", {31'h0, ok}, 32'h1);
    chk("no_mid_drop", 32'(bad), 32'h0);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      rd_status(st);
      if (st != 32'h2) bad++;
    end
    chk("single_capture", 32'(bad), 32'h0);

    check_buffer(512);

    // Reset in the middle of a capture, then a clean capture.
    arm();
    repeat (40) @(posedge mem_clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge mem_clk);
    #1;
    chk("midrst_ret", {31'h0, |bus.mem_packed_ret}, 32'h0);
    reset = 1'b1;
    repeat (5) @(posedge mem_clk);
    rd_status(st);
    chk("midrst_status", st, 32'h0);
    repeat (500) @(posedge mem_clk);
    rd_status(st);
    chk("abort_stays_idle", st, 32'h0);
    arm();
    wait_done(ok, bad);
    chk("rearm_done", {31'h0, ok}, 32'h1);
    chk("rearm_no_drop", 32'(bad), 32'h0);
    check_buffer(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
